// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: bus widths,
// default parameters, FSM state type and the address range helper.
package imem_responder_pkg;

  localparam int ADDR_SIZE  = 31;
  localparam int INSTR_SIZE = 31;

  localparam logic [INSTR_SIZE:0] INSTR_NOP = 32'h0000_0013;  // addi x0,x0,0
  localparam int IMEM_DEPTH = 1024;
  localparam int IMEM_WAIT  = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_e;

  // Range check done at 64 bits so base+size never wraps around 2^32.
  function automatic logic addr_in_range(input logic [ADDR_SIZE:0] addr,
                                         input logic [ADDR_SIZE:0] base,
                                         input int                 depth_words);
    logic [63:0] lim;
    lim = 64'(base) + 64'(depth_words) * 64'd4;
    return (64'(addr) >= 64'(base)) && (64'(addr) < lim);
  endfunction

endpackage

// File: rtl/imem_responder_array.sv
// Word-array RAM: one synchronous read port, one synchronous write port.
// Read-first on a same-edge collision; contents are never reset.
module imem_array #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 32,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             re_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Read port; register only moves on a read so the word holds during stalls.
  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory slave on the fetch read port. Accepts an address when
// rd_enable is high, returns the word after 1+WAIT_STATES cycles and holds
// it while fetch stalls. Out-of-range reads complete with NOP and rd_error.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int                  DEPTH_WORDS = IMEM_DEPTH,
  parameter logic [ADDR_SIZE:0]  BASE_ADDR   = 32'h0,
  parameter int                  WAIT_STATES = IMEM_WAIT,
  parameter logic [INSTR_SIZE:0] NOP_WORD    = INSTR_NOP
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_SIZE:0]    rd_addr,
  input  logic                  rd_enable,
  output logic [INSTR_SIZE:0]   rd_data,
  output logic                  rd_ready,
  output logic                  rd_error,
  input  logic                  ld_enable,
  input  logic [ADDR_SIZE:0]    ld_addr,
  input  logic [INSTR_SIZE:0]   ld_data
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_SIZE:0]   addr_q, addr_d;
  logic                 nop_q, nop_d;   // drive NOP_WORD instead of RAM data
  logic                 err_q, err_d;

  logic [ADDR_SIZE:0]   sel_addr, sel_off, ld_off;
  logic                 sel_in, ld_in, rd_re;
  logic [IDX_W-1:0]     sel_idx, ld_idx;
  logic [INSTR_SIZE:0]  ram_rdata;
  logic                 unused_off_bits;

  // While waiting the RAM is read from the captured address; otherwise the
  // read is issued straight from the live request so zero-wait reads land
  // one edge after the address is presented.
  assign sel_addr = (state_q == ST_BUSY) ? addr_q : rd_addr;
  assign sel_off  = sel_addr - BASE_ADDR;
  assign ld_off   = ld_addr - BASE_ADDR;
  assign sel_idx  = sel_off[IDX_W+1:2];
  assign ld_idx   = ld_off[IDX_W+1:2];
  assign sel_in   = addr_in_range(sel_addr, BASE_ADDR, DEPTH_WORDS);
  assign ld_in    = addr_in_range(ld_addr, BASE_ADDR, DEPTH_WORDS);

  // Byte-offset and above-array bits carry no index information.
  assign unused_off_bits = ^{sel_off[1:0], sel_off[ADDR_SIZE:IDX_W+2],
                             ld_off[1:0],  ld_off[ADDR_SIZE:IDX_W+2]};

  imem_array #(
    .DEPTH (DEPTH_WORDS),
    .WIDTH (INSTR_SIZE + 1),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .re_i    (rd_re & ~reset),
    .raddr_i (sel_idx),
    .rdata_o (ram_rdata),
    .we_i    (ld_enable & ld_in),
    .waddr_i (ld_idx),
    .wdata_i (ld_data)
  );

  // Next-state: accept, count down wait states, complete or redirect.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    nop_d   = nop_q;
    err_d   = err_q;
    rd_re   = 1'b0;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (rd_enable) begin
          addr_d = rd_addr;
          if (WAIT_STATES == 0) begin
            state_d = ST_RESP;
            rd_re   = 1'b1;
            nop_d   = ~sel_in;
            err_d   = ~sel_in;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_BUSY: begin
        if (rd_enable && (rd_addr != addr_q)) begin
          // Fetch redirected (flush): drop the old request and restart.
          addr_d = rd_addr;
          cnt_d  = CNT_LOAD;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RESP;
          rd_re   = 1'b1;
          nop_d   = ~sel_in;
          err_d   = ~sel_in;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and response-hold registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      nop_q   <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      nop_q   <= nop_d;
      err_q   <= err_d;
    end
  end

  assign rd_ready = (state_q == ST_RESP);
  assign rd_error = err_q;
  assign rd_data  = nop_q ? NOP_WORD : ram_rdata;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: a zero-wait instance (vector table plus random
// traffic against a transaction-level model) and a two-wait-state instance
// (hand-written latency, redirect and reset sequences).
module tb_imem_responder;

  localparam int          DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_en;
  logic [31:0] ld_addr, ld_data;
  logic        en0, en1;
  logic [31:0] addr0, addr1;
  logic [31:0] data0, data1;
  logic        rdy0, rdy1, err0, err1;

  int total = 0;
  int pass  = 0;

  always #5 clk = ~clk;

  imem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_STATES(0), .NOP_WORD(NOP)) dut0 (
    .clk(clk), .reset(rst), .rd_addr(addr0), .rd_enable(en0), .rd_data(data0),
    .rd_ready(rdy0), .rd_error(err0), .ld_enable(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  imem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_STATES(2), .NOP_WORD(NOP)) dut1 (
    .clk(clk), .reset(rst), .rd_addr(addr1), .rd_enable(en1), .rd_data(data1),
    .rd_ready(rdy1), .rd_error(err1), .ld_enable(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  // Transaction-level model of the zero-wait instance.
  logic [31:0] mem [DEPTH];
  logic        m_rdy;
  logic [31:0] m_data;
  logic        m_err;

  function automatic logic in_rng(input logic [31:0] a);
    return longint'(a) < longint'(4 * DEPTH);
  endfunction

  // Advance one clock; the model consumes the inputs presented before the edge.
  task automatic tick();
    if (rst) begin
      m_rdy = 1'b0; m_data = NOP; m_err = 1'b0;
    end else if (en0) begin
      m_rdy = 1'b1;
      if (in_rng(addr0)) begin m_data = mem[addr0 >> 2]; m_err = 1'b0; end
      else begin m_data = NOP; m_err = 1'b1; end
    end
    if (ld_en && in_rng(ld_addr)) mem[ld_addr >> 2] = ld_data;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        en;
    logic [31:0] addr;
    logic        rdy;
    logic [31:0] data;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    en0 = 1'b0; en1 = 1'b0; addr0 = '0; addr1 = '0;

    // Preload while reset is held: the array is not under reset.
    for (int i = 0; i < DEPTH; i++) begin
      ld_en = 1'b1; ld_addr = 32'(i * 4); ld_data = 32'h1000_0000 + 32'(i);
      tick();
    end
    ld_en = 1'b0;
    tick();
    rst = 1'b0;

    chk("reset_rdy0",  32'(rdy0), 32'd0);
    chk("reset_data0", data0, NOP);
    chk("reset_err0",  32'(err0), 32'd0);
    chk("reset_rdy1",  32'(rdy1), 32'd0);
    chk("reset_data1", data1, NOP);
    tick();
    chk("idle_no_en_rdy0", 32'(rdy0), 32'd0);

    // Zero-wait pipeline, stall, range boundary and no-wrap vectors.
    vecs.push_back('{1'b1, 32'h0000_0000, 1'b1, 32'h1000_0000, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0004, 1'b1, 32'h1000_0001, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0008, 1'b1, 32'h1000_0002, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_000C, 1'b1, 32'h1000_0002, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_000C, 1'b1, 32'h1000_0002, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_000C, 1'b1, 32'h1000_0002, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_000C, 1'b1, 32'h1000_0003, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0100, 1'b1, NOP,           1'b1});
    vecs.push_back('{1'b1, 32'h0000_0014, 1'b1, 32'h1000_0005, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_00FF, 1'b1, 32'h1000_003F, 1'b0});
    vecs.push_back('{1'b1, 32'hFFFF_FFFC, 1'b1, NOP,           1'b1});
    vecs.push_back('{1'b0, 32'h0000_0000, 1'b1, NOP,           1'b1});
    foreach (vecs[i]) begin
      en0 = vecs[i].en; addr0 = vecs[i].addr;
      tick();
      chk($sformatf("vec%0d_rdy", i),  32'(rdy0), 32'(vecs[i].rdy));
      chk($sformatf("vec%0d_data", i), data0, vecs[i].data);
      chk($sformatf("vec%0d_err", i),  32'(err0), 32'(vecs[i].err));
    end

    // Same-edge load and read of one word returns the old contents.
    en0 = 1'b1; addr0 = 32'h4;
    ld_en = 1'b1; ld_addr = 32'h4; ld_data = 32'hDEAD_BEEF;
    tick();
    chk("rdfirst_old", data0, 32'h1000_0001);
    ld_en = 1'b0;
    tick();
    chk("rdfirst_new", data0, 32'hDEAD_BEEF);
    en0 = 1'b0;

    // Two wait states: ready low for two cycles, then the word.
    en1 = 1'b1; addr1 = 32'h10;
    tick();
    chk("w2_busy1_rdy", 32'(rdy1), 32'd0);
    en1 = 1'b0;
    tick();
    chk("w2_busy2_rdy", 32'(rdy1), 32'd0);
    tick();
    chk("w2_resp_rdy",  32'(rdy1), 32'd1);
    chk("w2_resp_data", data1, 32'h1000_0004);
    tick();
    chk("w2_hold_data", data1, 32'h1000_0004);

    // Redirect mid-wait: old request abandoned, new word after three cycles.
    en1 = 1'b1; addr1 = 32'h10;
    tick();
    chk("redir_busy_rdy", 32'(rdy1), 32'd0);
    addr1 = 32'h20;
    tick();
    chk("redir_c1_rdy", 32'(rdy1), 32'd0);
    en1 = 1'b0;
    tick();
    chk("redir_c2_rdy", 32'(rdy1), 32'd0);
    tick();
    chk("redir_c3_rdy",  32'(rdy1), 32'd1);
    chk("redir_c3_data", data1, 32'h1000_0008);

    // Reset while waiting discards the request; memory survives.
    en1 = 1'b1; addr1 = 32'h18;
    tick();
    rst = 1'b1; en1 = 1'b0;
    tick();
    chk("rstbusy_rdy",  32'(rdy1), 32'd0);
    chk("rstbusy_data", data1, NOP);
    chk("rstbusy_err",  32'(err1), 32'd0);
    rst = 1'b0;
    tick();
    chk("rstbusy_idle_rdy", 32'(rdy1), 32'd0);
    en1 = 1'b1;
    tick();
    en1 = 1'b0;
    tick();
    tick();
    chk("reread_rdy",  32'(rdy1), 32'd1);
    chk("reread_data", data1, 32'h1000_0006);

    // Random traffic on the zero-wait instance against the model.
    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(0, 59) == 0);
      en0   = ($urandom_range(0, 3) != 0);
      addr0 = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 4 * DEPTH - 1));
      ld_en = ($urandom_range(0, 2) == 0);
      ld_addr = ($urandom_range(0, 7) == 0) ? 32'(4 * DEPTH) + 32'($urandom_range(0, 64))
                                            : 32'($urandom_range(0, 4 * DEPTH - 1));
      ld_data = 32'($urandom);
      tick();
      chk("rand_rdy",  32'(rdy0), 32'(m_rdy));
      chk("rand_data", data0, m_data);
      chk("rand_err",  32'(err0), 32'(m_err));
    end

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
